// File: rtl/uart_tx_rr_arbiter.sv
// Round-robin arbiter sharing one UART TX byte sink between NUM_REQ sources, with a skid
// register per grant and a programmable post-accept idle gap. Optional lock: UART_TX_ARB_LOCK_EN.
module uart_tx_rr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_REQ-1:0]            s_axis_tvalid,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            s_axis_tlast,
`endif
    output logic [NUM_REQ-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic [15:0]                   gap,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic [1:0]                    dbg_state
);

    // Handshakes: a beat transfers on a rising clk edge where valid and ready are both 1;
    // a source keeps valid/data stable until then, and ready never depends on a future cycle.

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ID_W-1:0]         r_ptr;
    logic [ID_W-1:0]         r_grant_id;
    logic [DATA_WIDTH-1:0]   r_tdata;
    logic                    r_tvalid;
    logic [15:0]             r_cnt;

    logic [NUM_REQ-1:0]      w_eligible;
    logic                    w_found;
    logic [ID_W-1:0]         w_winner;
    logic [ID_W-1:0]         w_idx;
    logic [DATA_WIDTH-1:0]   w_win_data;
    logic                    w_hs;
    logic                    w_accept;

`ifdef UART_TX_ARB_LOCK_EN
    logic                    r_locked;
    logic [ID_W-1:0]         r_lock_id;

    // While locked only the lock owner may compete, even when it is idle.
    always_comb begin
        w_eligible = s_axis_tvalid;
        if (r_locked) begin
            w_eligible = '0;
            w_eligible[r_lock_id] = s_axis_tvalid[r_lock_id];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked  <= 1'b0;
            r_lock_id <= '0;
        end else if (w_hs) begin
            r_locked  <= ~s_axis_tlast[w_winner];
            r_lock_id <= w_winner;
        end
    end
`else
    assign w_eligible = s_axis_tvalid;
`endif

    // Search starts one past the last winner so every valid source is reached within NUM_REQ grants.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && w_eligible[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_win_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_hs     = (r_state == ST_ARB) && w_found;
    assign w_accept = (r_state == ST_SEND) && m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ARB: begin
                if (w_found) begin
                    w_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_axis_tready) begin
                    w_next = (gap == 16'd0) ? ST_ARB : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_cnt == 16'd0) begin
                    w_next = ST_ARB;
                end
            end
            default: w_next = ST_ARB;
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        busy          = 1'b1;
        if (r_state == ST_ARB) begin
            busy = 1'b0;
            if (w_found) begin
                s_axis_tready[w_winner] = 1'b1;
            end
        end
    end

    // cnt is loaded with gap-1 so ARB is re-entered exactly gap clks after the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= ID_W'(NUM_REQ - 1);
            r_grant_id <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_cnt      <= 16'd0;
        end else begin
            if (w_hs) begin
                r_tdata    <= w_win_data;
                r_tvalid   <= 1'b1;
                r_ptr      <= w_winner;
                r_grant_id <= w_winner;
            end
            if (w_accept) begin
                r_tvalid <= 1'b0;
                if (gap != 16'd0) begin
                    r_cnt <= gap - 16'd1;
                end
            end else if (r_state == ST_GAP && r_cnt != 16'd0) begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign grant_id      = r_grant_id;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Self-checking bench for uart_tx_rr_arbiter: vector table, hand-written corner sequences
// and randomized traffic against a timestamp-based reference model.
module tb_uart_tx_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*DW-1:0]  s_tdata;
    logic [NR-1:0]     s_tvalid;
`ifdef UART_TX_ARB_LOCK_EN
    logic [NR-1:0]     s_tlast;
`endif
    logic [NR-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [15:0]       gap;
    logic [1:0]        grant_id;
    logic              busy;
    logic [1:0]        dbg_state;

    int     n_pass  = 0;
    int     n_total = 0;
    longint cyc     = 0;

    // reference model: arbitration free from cycle m_ready_at, held bytes in exp_q
    logic [DW-1:0] exp_q[$];
    bit            m_hold;
    int            m_ptr;
    int            m_gid;
    longint        m_ready_at;

    uart_tx_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
`ifdef UART_TX_ARB_LOCK_EN
        .s_axis_tlast  (s_tlast),
`endif
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .gap           (gap),
        .grant_id      (grant_id),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = '0;
        s_tdata  = '0;
        m_tready = 1'b0;
        gap      = 16'd0;
`ifdef UART_TX_ARB_LOCK_EN
        s_tlast  = '1;
`endif
        tick();
        tick();
        rst        = 1'b0;
        cyc        = 0;
        m_hold     = 1'b0;
        m_ptr      = NR - 1;
        m_gid      = 0;
        m_ready_at = 0;
        exp_q.delete();
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NR-1:0]    valid;
        logic [NR*DW-1:0] data;
        logic             mready;
        logic [15:0]      gap;
        logic [NR-1:0]    exp_tready;
        logic             exp_tvalid;
        logic [DW-1:0]    exp_tdata;
        logic [1:0]       exp_gid;
        logic             exp_busy;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic [3:0] v, logic [31:0] d, logic [3:0] tr,
                                logic tv, logic [7:0] td, logic [1:0] g, logic b);
        vec_t r;
        r.valid      = v;
        r.data       = d;
        r.mready     = 1'b1;
        r.gap        = 16'd0;
        r.exp_tready = tr;
        r.exp_tvalid = tv;
        r.exp_tdata  = td;
        r.exp_gid    = g;
        r.exp_busy   = b;
        return r;
    endfunction

    task automatic run_table();
        for (int i = 0; i < 18; i++) begin
            s_tvalid = vecs[i].valid;
            s_tdata  = vecs[i].data;
            m_tready = vecs[i].mready;
            gap      = vecs[i].gap;
            #1;
            chk($sformatf("vec%0d tready", i), 32'(s_tready), 32'(vecs[i].exp_tready));
            chk($sformatf("vec%0d tvalid", i), 32'(m_tvalid), 32'(vecs[i].exp_tvalid));
            if (vecs[i].exp_tvalid) begin
                chk($sformatf("vec%0d tdata", i), 32'(m_tdata), 32'(vecs[i].exp_tdata));
            end
            chk($sformatf("vec%0d grant_id", i), 32'(grant_id), 32'(vecs[i].exp_gid));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            tick();
        end
    endtask

    // ---------------- hand-written sequences ----------------
    task automatic reset_idle_test();
        rst      = 1'b1;
        s_tvalid = '0;
        s_tdata  = '1;
        m_tready = 1'b1;
        gap      = 16'd3;
        tick();
        chk("rst tvalid", 32'(m_tvalid), 32'd0);
        chk("rst tdata", 32'(m_tdata), 32'd0);
        chk("rst grant_id", 32'(grant_id), 32'd0);
        chk("rst state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("idle tready", 32'(s_tready), 32'd0);
            chk("idle tvalid", 32'(m_tvalid), 32'd0);
            chk("idle busy", 32'(busy), 32'd0);
            chk("idle grant_id", 32'(grant_id), 32'd0);
            tick();
        end
    endtask

    task automatic stall_test();
        do_reset();
        s_tvalid = 4'b0100;
        s_tdata  = 32'h00A70000;
        m_tready = 1'b0;
        #1;
        chk("stall grant", 32'(s_tready), 32'b0100);
        tick();
        s_tvalid = '1;
        s_tdata  = 32'h12345678;
        for (int k = 0; k < 20; k++) begin
            #1;
            chk("stall tvalid", 32'(m_tvalid), 32'd1);
            chk("stall tdata", 32'(m_tdata), 32'hA7);
            chk("stall tready", 32'(s_tready), 32'd0);
            tick();
        end
        m_tready = 1'b1;
        #1;
        chk("stall release tvalid", 32'(m_tvalid), 32'd1);
        tick();
        #1;
        chk("post stall tvalid", 32'(m_tvalid), 32'd0);
        chk("post stall winner", 32'(s_tready), 32'b1000);
    endtask

    task automatic gap_test(input logic [15:0] g, input int bound, input string nm);
        int n;
        bit seen;
        do_reset();
        s_tvalid = 4'b0010;
        s_tdata  = 32'h00006600;
        m_tready = 1'b1;
        gap      = g;
        #1;
        chk({nm, " grant"}, 32'(s_tready), 32'b0010);
        tick();
        #1;
        chk({nm, " tvalid"}, 32'(m_tvalid), 32'd1);
        tick();
        gap  = 16'd2;
        n    = 0;
        seen = 1'b0;
        while (n < bound) begin
            #1;
            if (s_tready != '0) begin
                seen = 1'b1;
                break;
            end
            if (busy !== 1'b1) begin
                chk({nm, " busy in gap"}, 32'(busy), 32'd1);
            end
            tick();
            n++;
        end
        if (!seen) begin
            chk({nm, " timeout"}, 32'(n), 32'(g));
        end else begin
            chk({nm, " clks to tready"}, 32'(n), 32'(g));
            chk({nm, " tready id"}, 32'(s_tready), 32'b0010);
        end
    endtask

    task automatic reset_mid_frame_test();
        do_reset();
        s_tvalid = 4'b0010;
        s_tdata  = 32'h00003C00;
        m_tready = 1'b0;
        tick();
        #1;
        chk("midrst tvalid before", 32'(m_tvalid), 32'd1);
        rst      = 1'b1;
        s_tvalid = '0;
        tick();
        #1;
        chk("midrst tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst grant_id", 32'(grant_id), 32'd0);
        rst      = 1'b0;
        s_tvalid = 4'b0011;
        #1;
        chk("midrst next winner", 32'(s_tready), 32'b0001);
        tick();
    endtask

`ifdef UART_TX_ARB_LOCK_EN
    task automatic lock_test();
        logic [7:0] got_q[$];
        logic [7:0] want[4];
        int b2;
        bit hs0;
        bit hs2;
        want[0] = 8'hA1;
        want[1] = 8'hB2;
        want[2] = 8'hC3;
        want[3] = 8'h5A;
        do_reset();
        gap      = 16'd1;
        m_tready = 1'b1;
        s_tlast  = 4'b0001;
        s_tdata  = 32'h00A1005A;
        s_tvalid = 4'b0100;
        #1;
        chk("lock A grant", 32'(s_tready), 32'b0100);
        tick();
        s_tvalid = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (m_tvalid && m_tready) got_q.push_back(m_tdata);
            chk("lock owner idle tready", 32'(s_tready), 32'd0);
            tick();
        end
        s_tvalid = 4'b0101;
        s_tdata  = 32'h00B2005A;
        b2 = 1;
        for (int k = 0; k < 40 && got_q.size() < 4; k++) begin
            #1;
            if (m_tvalid && m_tready) got_q.push_back(m_tdata);
            hs2 = s_tready[2];
            hs0 = s_tready[0];
            tick();
            if (hs2) begin
                b2++;
                if (b2 == 2) begin
                    s_tdata[23:16] = 8'hC3;
                    s_tlast[2]     = 1'b1;
                end else begin
                    s_tvalid[2] = 1'b0;
                end
            end
            if (hs0) s_tvalid[0] = 1'b0;
        end
        chk("lock byte count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            chk($sformatf("lock order %0d", i), 32'(got_q[i]), 32'(want[i]));
        end

        // reset while B is held must drop it and clear the lock
        do_reset();
        gap      = 16'd0;
        m_tready = 1'b1;
        s_tlast  = 4'b0000;
        s_tdata  = 32'h00A1005A;
        s_tvalid = 4'b0100;
        tick();
        tick();
        s_tdata  = 32'h00B2005A;
        tick();
        m_tready = 1'b0;
        #1;
        chk("lock rst B held", 32'(m_tdata), 32'hB2);
        rst = 1'b1;
        tick();
        #1;
        chk("lock rst tvalid", 32'(m_tvalid), 32'd0);
        rst      = 1'b0;
        s_tvalid = 4'b0001;
        #1;
        chk("lock cleared", 32'(s_tready), 32'b0001);
        tick();
    endtask
`endif

    // ---------------- randomized traffic vs model ----------------
    task automatic run_random(input int ncyc);
        logic [NR-1:0]    v;
        logic [NR*DW-1:0] d;
        logic             mr;
        logic [15:0]      g;
        logic [NR-1:0]    exp_tr;
        int               exp_win;
        int               idx;
        do_reset();
        for (int n = 0; n < ncyc; n++) begin
            v  = NR'($urandom_range(0, 15));
            d  = $urandom();
            mr = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) g = 16'($urandom_range(4, 12));
            else                           g = 16'($urandom_range(0, 2));
            s_tvalid = v;
            s_tdata  = d;
            m_tready = mr;
            gap      = g;
            exp_tr   = '0;
            exp_win  = 0;
            if (!m_hold && cyc >= m_ready_at) begin
                for (int k = 1; k <= NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (v[idx] && exp_tr == '0) begin
                        exp_tr[idx] = 1'b1;
                        exp_win     = idx;
                    end
                end
            end
            #1;
            chk("rnd tready", 32'(s_tready), 32'(exp_tr));
            chk("rnd tvalid", 32'(m_tvalid), 32'(m_hold));
            if (m_hold && exp_q.size() > 0) chk("rnd tdata", 32'(m_tdata), 32'(exp_q[0]));
            chk("rnd grant_id", 32'(grant_id), 32'(m_gid));
            chk("rnd busy", 32'(busy), 32'(m_hold || cyc < m_ready_at));
            if (exp_tr != '0) begin
                m_hold = 1'b1;
                exp_q.push_back(d[exp_win*DW +: DW]);
                m_ptr = exp_win;
                m_gid = exp_win;
            end else if (m_hold && mr) begin
                m_hold = 1'b0;
                void'(exp_q.pop_front());
                m_ready_at = cyc + 1 + longint'(g);
            end
            tick();
        end
    endtask

    // ---------------- main ----------------
    initial begin
        vecs[0]  = mk(4'b0000, 32'h44332211, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[1]  = mk(4'b0000, 32'h44332211, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[2]  = mk(4'b1111, 32'h44332211, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[3]  = mk(4'b1111, 32'h44332211, 4'b0000, 1'b1, 8'h11, 2'd0, 1'b1);
        vecs[4]  = mk(4'b1111, 32'h44332211, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[5]  = mk(4'b1111, 32'h44332211, 4'b0000, 1'b1, 8'h22, 2'd1, 1'b1);
        vecs[6]  = mk(4'b1111, 32'h44332211, 4'b0100, 1'b0, 8'h00, 2'd1, 1'b0);
        vecs[7]  = mk(4'b1111, 32'h44332211, 4'b0000, 1'b1, 8'h33, 2'd2, 1'b1);
        vecs[8]  = mk(4'b1111, 32'h44332211, 4'b1000, 1'b0, 8'h00, 2'd2, 1'b0);
        vecs[9]  = mk(4'b1111, 32'h44332211, 4'b0000, 1'b1, 8'h44, 2'd3, 1'b1);
        vecs[10] = mk(4'b1111, 32'h44332211, 4'b0001, 1'b0, 8'h00, 2'd3, 1'b0);
        vecs[11] = mk(4'b1111, 32'h44332211, 4'b0000, 1'b1, 8'h11, 2'd0, 1'b1);
        vecs[12] = mk(4'b1111, 32'h44332211, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[13] = mk(4'b1111, 32'h44332211, 4'b0000, 1'b1, 8'h22, 2'd1, 1'b1);
        vecs[14] = mk(4'b0000, 32'h44332211, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0);
        vecs[15] = mk(4'b0001, 32'h44332255, 4'b0001, 1'b0, 8'h00, 2'd1, 1'b0);
        vecs[16] = mk(4'b0000, 32'h44332255, 4'b0000, 1'b1, 8'h55, 2'd0, 1'b1);
        vecs[17] = mk(4'b0000, 32'h44332255, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);

        reset_idle_test();
        do_reset();
        run_table();
        stall_test();
        gap_test(16'd5, 100, "gap5");
        gap_test(16'hFFFF, 70000, "gapmax");
        reset_mid_frame_test();
`ifdef UART_TX_ARB_LOCK_EN
        lock_test();
`endif
        run_random(1500);
        run_random(1500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
